// File: rtl/cla_adder_64.sv
// 64-bit carry-lookahead adder: three-level 4-way lookahead network (groups, blocks, top)
// feeding a registered sum and carry-out.
module cla_adder_64 (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        c_in,
   output logic [63:0] sum,
   output logic        c_out
);

   // Carries for four positions from a shared carry-in; bit 0 is the carry-in itself.
   function automatic logic [3:0] la_carry(input logic [3:0] gg, input logic [3:0] pp,
                                           input logic ci);
      logic [3:0] cc;
      cc[0] = ci;
      cc[1] = gg[0] | (pp[0] & ci);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
      return cc;
   endfunction

   // Returns {G, P} for a span of four positions.
   function automatic logic [1:0] la_gp(input logic [3:0] gg, input logic [3:0] pp);
      logic gen;
      gen = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
      return {gen, &pp};
   endfunction

   logic [63:0] g;
   logic [63:0] p;
   logic [63:0] c;
   logic [15:0] grp_g;
   logic [15:0] grp_p;
   logic [15:0] grp_c;
   logic [3:0]  blk_g;
   logic [3:0]  blk_p;
   logic [3:0]  blk_c;
   logic        top_g;
   logic        top_p;
   logic        c64;
   logic [63:0] sum_d;
   logic [63:0] sum_q;
   logic        c_out_q;

   assign g = a & b;
   assign p = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_grp
         assign c[4*gi +: 4] = la_carry(g[4*gi +: 4], p[4*gi +: 4], grp_c[gi]);
         assign {grp_g[gi], grp_p[gi]} = la_gp(g[4*gi +: 4], p[4*gi +: 4]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_blk
         assign grp_c[4*gi +: 4] = la_carry(grp_g[4*gi +: 4], grp_p[4*gi +: 4], blk_c[gi]);
         assign {blk_g[gi], blk_p[gi]} = la_gp(grp_g[4*gi +: 4], grp_p[4*gi +: 4]);
      end
   endgenerate

   assign blk_c          = la_carry(blk_g, blk_p, c_in);
   assign {top_g, top_p} = la_gp(blk_g, blk_p);
   assign c64            = top_g | (top_p & c_in);
   assign sum_d          = p ^ c;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= 64'd0;
         c_out_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c64;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_cla_adder_64.sv
// Directed and random checks of cla_adder_64 against hand-computed sums and a 65-bit reference add.
module tb_cla_adder_64;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a;
   logic [63:0] b;
   logic        c_in;
   logic [63:0] sum;
   logic        c_out;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   cla_adder_64 dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   // Drive operands, then sample one cycle later away from the edge.
   task automatic step(input logic r, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci);
      rst  = r;
      a    = av;
      b    = bv;
      c_in = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, ONES, ONES, 1'b1);
      total++;
      if ({c_out, sum} !== 65'd0) begin
         bad++;
         $display("FAIL reset_edge1 got c_out=%b sum=%h want 0/0", c_out, sum);
      end
      $display("txn reset_edge1 c_out=%b sum=%h", c_out, sum);
      step(1'b1, ONES, ONES, 1'b1);
      total++;
      if ({c_out, sum} !== 65'd0) begin
         bad++;
         $display("FAIL reset_edge2 got c_out=%b sum=%h want 0/0", c_out, sum);
      end
      $display("txn reset_edge2 c_out=%b sum=%h", c_out, sum);
   endtask

   task automatic test_zero_chain();
      step(1'b0, 64'd0, 64'd0, 1'b0);
      total++;
      if ({c_out, sum} !== 65'd0) begin
         bad++;
         $display("FAIL zero got c_out=%b sum=%h want 0/0", c_out, sum);
      end
      $display("txn zero c_out=%b sum=%h", c_out, sum);
      step(1'b0, ONES, 64'd0, 1'b1);
      total++;
      if ({c_out, sum} !== {1'b1, 64'd0}) begin
         bad++;
         $display("FAIL full_chain got c_out=%b sum=%h want 1/0", c_out, sum);
      end
      $display("txn full_chain c_out=%b sum=%h", c_out, sum);
   endtask

   task automatic test_saturated();
      step(1'b0, ONES, ONES, 1'b1);
      total++;
      if ({c_out, sum} !== {1'b1, ONES}) begin
         bad++;
         $display("FAIL saturated got c_out=%b sum=%h want 1/%h", c_out, sum, ONES);
      end
      $display("txn saturated c_out=%b sum=%h", c_out, sum);
      step(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      total++;
      if ({c_out, sum} !== {1'b1, 64'd0}) begin
         bad++;
         $display("FAIL top_bit got c_out=%b sum=%h want 1/0", c_out, sum);
      end
      $display("txn top_bit c_out=%b sum=%h", c_out, sum);
   endtask

   task automatic test_boundaries();
      logic [63:0] av [5];
      logic        cv [5];
      logic [63:0] ev [5];
      av[0] = 64'h0000_0000_0000_000F; cv[0] = 1'b0; ev[0] = 64'h0000_0000_0000_0010;
      av[1] = 64'h0000_0000_0000_FFFF; cv[1] = 1'b0; ev[1] = 64'h0000_0000_0001_0000;
      av[2] = 64'h0000_0000_FFFF_FFFF; cv[2] = 1'b0; ev[2] = 64'h0000_0001_0000_0000;
      av[3] = 64'h0000_FFFF_FFFF_FFFF; cv[3] = 1'b0; ev[3] = 64'h0001_0000_0000_0000;
      av[4] = 64'h0000_0000_0000_00FE; cv[4] = 1'b1; ev[4] = 64'h0000_0000_0000_0100;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, av[i], 64'd1, cv[i]);
         total++;
         if ({c_out, sum} !== {1'b0, ev[i]}) begin
            bad++;
            $display("FAIL boundary%0d got c_out=%b sum=%h want 0/%h", i, c_out, sum, ev[i]);
         end
         $display("txn boundary%0d c_out=%b sum=%h", i, c_out, sum);
      end
   endtask

   task automatic test_sext();
      step(1'b0, 64'h0000_0000_1215_3524, 64'hFFFF_FFFF_C089_5E81, 1'b0);
      total++;
      if ({c_out, sum} !== {1'b0, 64'hFFFF_FFFF_D29E_93A5}) begin
         bad++;
         $display("FAIL sext got c_out=%b sum=%h want 0/ffffffffd29e93a5", c_out, sum);
      end
      $display("txn sext c_out=%b sum=%h", c_out, sum);
   endtask

   task automatic test_back_to_back();
      logic [63:0] av;
      logic [63:0] bv;
      logic        cv;
      logic [64:0] exp_r;
      int          bad_before;
      bad_before = bad;
      for (int i = 0; i < 10000; i++) begin
         av    = {$urandom(), $urandom()};
         bv    = {$urandom(), $urandom()};
         cv    = 1'($urandom_range(1, 0));
         if (i % 7 == 0) bv = ~av;
         exp_r = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
         step(1'b0, av, bv, cv);
         total++;
         if ({c_out, sum} !== exp_r) begin
            bad++;
            if (bad - bad_before <= 10)
               $display("FAIL random%0d got %b/%h want %b/%h", i, c_out, sum, exp_r[64],
                        exp_r[63:0]);
         end
      end
      $display("txn random batch of 10000 vectors, errors=%0d", bad - bad_before);
   endtask

   task automatic test_reset_midstream();
      step(1'b0, 64'd5, 64'd7, 1'b0);
      total++;
      if ({c_out, sum} !== 65'd12) begin
         bad++;
         $display("FAIL mid_pre got c_out=%b sum=%h want 0/c", c_out, sum);
      end
      $display("txn mid_pre c_out=%b sum=%h", c_out, sum);
      step(1'b1, 64'd100, 64'd200, 1'b1);
      total++;
      if ({c_out, sum} !== 65'd0) begin
         bad++;
         $display("FAIL mid_reset got c_out=%b sum=%h want 0/0", c_out, sum);
      end
      $display("txn mid_reset c_out=%b sum=%h", c_out, sum);
      step(1'b0, 64'd3, 64'd4, 1'b1);
      total++;
      if ({c_out, sum} !== 65'd8) begin
         bad++;
         $display("FAIL mid_post got c_out=%b sum=%h want 0/8", c_out, sum);
      end
      $display("txn mid_post c_out=%b sum=%h", c_out, sum);
   endtask

   initial begin
      rst  = 1'b1;
      a    = ONES;
      b    = ONES;
      c_in = 1'b1;
      test_reset();
      test_zero_chain();
      test_saturated();
      test_boundaries();
      test_sext();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
